// File: rtl/mux_n_to_1_rr.sv
// N-to-1 channel multiplexer with fixed-select or round-robin arbitration
// feeding a single registered output slot (EMPTY/FULL).
module mux_n_to_1_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    S,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_sel
);

  // Handshake: a beat moves on any edge where valid && ready are both high on
  // the same side. in_ready never depends on in_data; out_valid never depends
  // on out_ready. The slot accepts a new beat whenever it is empty or drains.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state;
  logic [SELW-1:0]  ptr;
  logic             load_en;
  logic             grant_vld;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  idx;
  logic [WIDTH-1:0] grant_data;

  assign out_valid = (state == ST_FULL);
  assign load_en   = !out_valid || out_ready;

  // Fixed mode ignores out-of-range selects; round-robin scans from ptr with wrap.
  always_comb begin : grant_search
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    if (!mode) begin
      if (int'(S) < N) begin
        grant_vld = in_valid[S];
        grant     = S;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = SELW'((int'(ptr) + k) % N);
        if (!grant_vld && in_valid[idx]) begin
          grant_vld = 1'b1;
          grant     = idx;
        end
      end
    end
  end

  always_comb begin : data_select
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Gated by rst_n so no channel sees a ready while reset is held.
  always_comb begin : ready_gen
    in_ready = '0;
    if (rst_n && load_en && grant_vld) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      out     <= '0;
      out_sel <= '0;
      ptr     <= '0;
    end else if (load_en) begin
      if (grant_vld) begin
        state   <= ST_FULL;
        out     <= grant_data;
        out_sel <= grant;
        if (mode) ptr <= (int'(grant) == N - 1) ? '0 : grant + SELW'(1);
      end else begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_to_1_rr.sv
// Bench for mux_n_to_1_rr: directed vectors, a queue-based arbitration model
// checked every negedge, and literal expectations for the key scenarios.
module tb_mux_n_to_1_rr;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N*WIDTH-1:0] in_data = '0;
  logic [N-1:0]       in_valid = '0;
  logic [N-1:0]       in_ready;
  logic               mode = 1'b0;
  logic [SELW-1:0]    S = '0;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [SELW-1:0]    out_sel;

  int checks = 0;
  int errors = 0;

  // model state
  logic             m_full = 1'b0;
  logic [WIDTH-1:0] m_out  = '0;
  int               m_sel  = 0;
  int               m_ptr  = 0;

  mux_n_to_1_rr #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .S(S), .out(out),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Which channel the rules say should win right now, or -1.
  function automatic int pick();
    int order[$];
    if (!mode) return (int'(S) < N && in_valid[S]) ? int'(S) : -1;
    for (int k = m_ptr; k < N; k++) order.push_back(k);
    for (int k = 0; k < m_ptr; k++) order.push_back(k);
    foreach (order[j]) if (in_valid[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    if (!rst_n) return r;
    if (m_full && !out_ready) return r;
    g = pick();
    if (g >= 0) r = N'(1) << g;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int g;
    if (!rst_n) begin
      m_full <= 1'b0;
      m_out  <= '0;
      m_sel  <= 0;
      m_ptr  <= 0;
    end else if (!m_full || out_ready) begin
      g = pick();
      if (g >= 0) begin
        m_full <= 1'b1;
        m_out  <= WIDTH'(in_data >> (g * WIDTH));
        m_sel  <= g;
        if (mode) m_ptr <= (g + 1) % N;
      end else begin
        m_full <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    chk("in_ready", 32'(in_ready), 32'(exp_ready()));
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("out", 32'(out), 32'(m_out));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
  end

  // driver task
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int seq_a[5] = '{0, 1, 2, 3, 0};
  int seq_b[4] = '{1, 3, 1, 3};
  logic [N-1:0] tbl_valid[12] = '{4'hF, 4'h5, 4'hA, 4'h0, 4'h8, 4'h1,
                                  4'h3, 4'hC, 4'h6, 4'h9, 4'h2, 4'hF};
  logic         tbl_ordy[12]  = '{1, 0, 1, 1, 1, 0, 1, 1, 0, 1, 1, 1};
  logic         tbl_mode[12]  = '{1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 1};

  initial begin
    // reset holds everything low even with requests present
    #2;
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out", 32'(out), 32'h0);
    step();
    chk("rst_hold_in_ready", 32'(in_ready), 32'h0);
    chk("rst_hold_out_sel", 32'(out_sel), 32'h0);
    in_valid = '0; mode = 1'b0;
    #2 rst_n = 1'b1;

    // fixed select, channel 2
    S = 2'd2; in_data = 32'h00A5_0000; in_valid = 4'b0100;
    #1;
    chk("fix_in_ready", 32'(in_ready), 32'h4);
    step();
    chk("fix_out", 32'(out), 32'hA5);
    chk("fix_out_sel", 32'(out_sel), 32'd2);
    chk("fix_out_valid", 32'(out_valid), 32'd1);

    // drain
    in_valid = '0;
    step();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_out_hold", 32'(out), 32'hA5);
    chk("drain_sel_hold", 32'(out_sel), 32'd2);

    // round-robin, all channels
    mode = 1'b1; in_valid = 4'hF; in_data = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_all_sel", 32'(out_sel), 32'(seq_a[i]));
    end

    // round-robin skip
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_skip_sel", 32'(out_sel), 32'(seq_b[i]));
    end

    // backpressure with 0x3C held; mode/S changes must not disturb it
    mode = 1'b0; S = 2'd0; in_valid = 4'b0001; in_data = 32'h1312_113C;
    step();
    chk("bp_load", 32'(out), 32'h3C);
    out_ready = 1'b0; mode = 1'b1; in_valid = 4'hF; in_data = 32'h1312_1177;
    for (int i = 0; i < 3; i++) begin
      S = SELW'(i + 1);
      step();
      chk("bp_out_hold", 32'(out), 32'h3C);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h1);
    step();
    chk("bp_next_out", 32'(out), 32'h77);
    chk("bp_next_sel", 32'(out_sel), 32'd0);

    // fixed select on an idle channel: no grant
    mode = 1'b0; S = 2'd3; in_valid = 4'b0111;
    #1;
    chk("idle_sel_ready", 32'(in_ready), 32'h0);
    step();
    chk("idle_sel_valid", 32'(out_valid), 32'd0);
    chk("idle_sel_hold", 32'(out), 32'h77);

    // reach FULL with ptr=3, then reset between edges
    mode = 1'b1; in_valid = 4'b0100;
    step();
    chk("pre_rst_sel", 32'(out_sel), 32'd2);
    in_valid = 4'hF; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out", 32'(out), 32'h0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_sel", 32'(out_sel), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'h0);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'h1);
    step();
    chk("post_rst_sel", 32'(out_sel), 32'd0);
    chk("post_rst_out", 32'(out), 32'h77);

    // mixed table, checked by the model only
    for (int i = 0; i < 12; i++) begin
      in_valid  = tbl_valid[i];
      out_ready = tbl_ordy[i];
      mode      = tbl_mode[i];
      S         = SELW'(i);
      in_data   = 32'h0102_0304 * (i + 1);
      step();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_n_to_1_rr.md
MUX_N_TO_1_RR -- requirements
Module: mux_n_to_1_rr

Interface
REQ-001 Parameter WIDTH, default 8: data bits per channel.
REQ-002 Parameter N, default 4: number of input channels; legal range 2..16.
REQ-003 Parameter SELW, default 2: select width; SHALL equal ceil(log2(N)).
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 in_data  input  N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N: per-channel valid.
REQ-008 in_ready  output  N: per-channel ready, combinational.
REQ-009 mode  input  1: 0 = fixed select by S; 1 = round-robin.
REQ-010 S  input  SELW: channel select, used only when mode=0.
REQ-011 out  output  WIDTH: registered output data.
REQ-012 out_valid  output  1: out holds a valid beat.
REQ-013 out_ready  input  1: downstream accepts the beat.
REQ-014 out_sel  output  SELW: index of the channel that supplied the current out beat.

Function
REQ-015 Output stage SHALL be a single register slot with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load_en SHALL be (!out_valid) || out_ready.
REQ-017 Grant, mode=0: grant=S if S<N and in_valid[S]=1; otherwise no grant.
REQ-018 Grant, mode=1: grant is the first index i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1; no grant if in_valid is all zero.
REQ-019 in_ready[i] SHALL be 1 only when load_en=1 and i is the grant; at most one bit is set per cycle.
REQ-020 Transfer on channel i occurs when in_valid[i] && in_ready[i]. On that edge, out <= channel i data, out_sel <= i, out_valid <= 1.
REQ-021 Latency SHALL be 1 cycle from input transfer to out_valid.
REQ-022 If load_en=1 and there is no grant, out_valid SHALL go to 0 on the next edge; out and out_sel hold their values.
REQ-023 If out_valid=1 and out_ready=0, out, out_sel and out_valid hold, and all in_ready are 0.
REQ-024 When FULL with out_ready=1 and a grant present, a new beat loads in the same cycle. Throughput is 1 beat/cycle with no bubble.
REQ-025 Round-robin pointer ptr (SELW bits, internal): on each transfer in mode=1, ptr <= grant+1, wrapping from N-1 to 0.
REQ-026 ptr SHALL NOT change on cycles without a transfer, or on transfers in mode=0.
REQ-027 A change to mode or S SHALL take effect on the current cycle's grant and SHALL NOT disturb a beat already held in the output register.
REQ-028 In mode=0 with S>=N (N not a power of 2): no grant, all in_ready=0; this is not an error.
REQ-029 Channels with in_valid=0 are skipped in mode=1. A single active channel SHALL be granted every cycle that load_en=1.

Reset
REQ-030 While rst_n=0, regardless of clk: out=0, out_valid=0, out_sel=0, ptr=0, and all in_ready=0.
REQ-031 Reset asserted mid-transfer discards the held beat. After rst_n rises, the first grant in mode=1 starts its search at channel 0.

Verification
REQ-032 Fixed mode (N=4, WIDTH=8): mode=0, S=2, in_data ch2=0xA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100; next cycle out=0xA5, out_sel=2, out_valid=1.
REQ-033 Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0.
REQ-034 Round-robin skip: mode=1, in_valid=4'b1010 held, out_ready=1 -> out_sel alternates 1,3,1,3.
REQ-035 Backpressure: FULL with out=0x3C, out_ready=0 for 3 cycles -> out=0x3C stable and in_ready=0 throughout; out_ready=1 -> new beat loads on the next edge.
REQ-036 Drain: in_valid=0, out_ready=1 while FULL -> out_valid=0 on the next edge; out holds its last value.
REQ-037 Async reset: rst_n low between clock edges while FULL and ptr=3 -> out=0, out_valid=0, out_sel=0 immediately; after rst_n rises, in mode=1 with all channels valid, channel 0 is granted first.
